// File: rtl/logic_engine_bist_if.sv
// Operand/result bus between the self-test initiator and an 8-bit logic engine.
//   eng_a, eng_b : operands driven by the initiator
//   eng_opcode   : 00 OR, 01 NAND, 10 NOR, 11 AND
//   eng_result   : engine output returned to the initiator
interface logic_engine_if;
    logic [7:0] eng_a;
    logic [7:0] eng_b;
    logic [1:0] eng_opcode;
    logic [7:0] eng_result;

    modport master (
        output eng_a,
        output eng_b,
        output eng_opcode,
        input  eng_result
    );

    modport slave (
        input  eng_a,
        input  eng_b,
        input  eng_opcode,
        output eng_result
    );
endinterface

// File: rtl/logic_engine_bist.sv
// On-chip self-test initiator for the 8-bit logic engine. Drives a directed
// corner-case table followed by LFSR vectors, checks each engine result
// against an internal golden value and keeps pass/fail/first-failure status.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : one-cycle pulse, honoured only when idle or done
//   eng                 : engine bus (operands out, result in)
//   busy, done          : run in progress / run complete
//   pass_count          : matching vectors (saturating)
//   fail_count          : mismatching vectors (saturating)
//   first_fail_*        : index, golden and engine values of the first mismatch
module logic_engine_bist #(
    parameter int unsigned NUM_RANDOM    = 256,
    parameter logic [7:0]  SEED_A        = 8'hA5,
    parameter logic [7:0]  SEED_B        = 8'h5A,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    logic_engine_if.master        eng,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           pass_count,
    output logic [15:0]           fail_count,
    output logic                  first_fail_valid,
    output logic [15:0]           first_fail_index,
    output logic [7:0]            first_fail_expected,
    output logic [7:0]            first_fail_got
);

    localparam int unsigned IDX_W    = 17;
    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    // One extra index bit so 7+NUM_RANDOM is representable for NUM_RANDOM up to 65535.
    localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(7 + NUM_RANDOM);
    localparam logic [7:0] SEED_A_EFF = (SEED_A == 8'h00) ? 8'h01 : SEED_A;
    localparam logic [7:0] SEED_B_EFF = (SEED_B == 8'h00) ? 8'h01 : SEED_B;
    localparam logic [7:0] LFSR_MASK  = 8'hB8;

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

    state_t              state;
    logic [IDX_W-1:0]    index;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [7:0]          lfsr_a;
    logic [7:0]          lfsr_b;
    logic [7:0]          golden;

    logic [7:0] vec_a_c;
    logic [7:0] vec_b_c;
    logic [1:0] vec_op_c;
    logic [7:0] vec_gold_c;

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {1'b0, x[7:1]} ^ (x[0] ? LFSR_MASK : 8'h00);
    endfunction

    // Operand selection: directed table for indices 0..7, LFSRs afterwards.
    always_comb begin
        vec_a_c  = lfsr_a;
        vec_b_c  = lfsr_b;
        vec_op_c = index[1:0];
        if (index < IDX_W'(8)) begin
            case (index[2:0])
                3'd0:    begin vec_a_c = 8'hAA; vec_b_c = 8'h55; vec_op_c = 2'b00; end
                3'd1:    begin vec_a_c = 8'hF0; vec_b_c = 8'h0F; vec_op_c = 2'b01; end
                3'd2:    begin vec_a_c = 8'hAA; vec_b_c = 8'h55; vec_op_c = 2'b10; end
                3'd3:    begin vec_a_c = 8'hF0; vec_b_c = 8'hCC; vec_op_c = 2'b11; end
                3'd4:    begin vec_a_c = 8'h00; vec_b_c = 8'h00; vec_op_c = 2'b00; end
                3'd5:    begin vec_a_c = 8'hFF; vec_b_c = 8'hFF; vec_op_c = 2'b11; end
                3'd6:    begin vec_a_c = 8'hA5; vec_b_c = 8'hAA; vec_op_c = 2'b01; end
                default: begin vec_a_c = 8'hFF; vec_b_c = 8'h00; vec_op_c = 2'b10; end
            endcase
        end
    end

    // Golden result of the vector about to be registered.
    always_comb begin
        case (vec_op_c)
            2'b00:   vec_gold_c = vec_a_c | vec_b_c;
            2'b01:   vec_gold_c = ~(vec_a_c & vec_b_c);
            2'b10:   vec_gold_c = ~(vec_a_c | vec_b_c);
            default: vec_gold_c = vec_a_c & vec_b_c;
        endcase
    end

    // Sequencer, operand registers and result bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            index               <= '0;
            settle_cnt          <= '0;
            lfsr_a              <= SEED_A_EFF;
            lfsr_b              <= SEED_B_EFF;
            golden              <= '0;
            eng.eng_a           <= '0;
            eng.eng_b           <= '0;
            eng.eng_opcode      <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            pass_count          <= '0;
            fail_count          <= '0;
            first_fail_valid    <= 1'b0;
            first_fail_index    <= '0;
            first_fail_expected <= '0;
            first_fail_got      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state               <= DRIVE;
                        busy                <= 1'b1;
                        done                <= 1'b0;
                        index               <= '0;
                        lfsr_a              <= SEED_A_EFF;
                        lfsr_b              <= SEED_B_EFF;
                        pass_count          <= '0;
                        fail_count          <= '0;
                        first_fail_valid    <= 1'b0;
                        first_fail_index    <= '0;
                        first_fail_expected <= '0;
                        first_fail_got      <= '0;
                    end
                end
                DRIVE: begin
                    eng.eng_a      <= vec_a_c;
                    eng.eng_b      <= vec_b_c;
                    eng.eng_opcode <= vec_op_c;
                    golden         <= vec_gold_c;
                    settle_cnt     <= '0;
                    // The LFSRs only move once a random vector has consumed them.
                    if (index >= IDX_W'(8)) begin
                        lfsr_a <= lfsr_step(lfsr_a);
                        lfsr_b <= lfsr_step(lfsr_b);
                    end
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                CHECK: begin
                    if (eng.eng_result == golden) begin
                        if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
                    end else begin
                        if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
                        if (!first_fail_valid) begin
                            first_fail_valid    <= 1'b1;
                            first_fail_index    <= index[15:0];
                            first_fail_expected <= golden;
                            first_fail_got      <= eng.eng_result;
                        end
                    end
                    if (index == LAST_INDEX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        index <= index + IDX_W'(1);
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_engine_bist.sv
// Directed-sequence bench for logic_engine_bist: two instances (default
// parameters, and a short run with a zero A seed and longer settle) each
// attached to a behavioural engine that can be ideal, stuck at zero or
// have NAND/NOR swapped.
module tb_logic_engine_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start0;
    logic start1;
    int   mode0;
    int   mode1;
    int   checks = 0;
    int   errors = 0;

    logic_engine_if bus0 ();
    logic_engine_if bus1 ();

    logic        busy0, done0, ffv0, busy1, done1, ffv1;
    logic [15:0] pass0, fail0, ffi0, pass1, fail1, ffi1;
    logic [7:0]  ffe0, ffg0, ffe1, ffg1;

    logic_engine_bist u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .eng(bus0.master),
        .busy(busy0), .done(done0), .pass_count(pass0), .fail_count(fail0),
        .first_fail_valid(ffv0), .first_fail_index(ffi0),
        .first_fail_expected(ffe0), .first_fail_got(ffg0)
    );

    logic_engine_bist #(
        .NUM_RANDOM(4), .SEED_A(8'h00), .SEED_B(8'h3C), .SETTLE_CYCLES(2)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .eng(bus1.master),
        .busy(busy1), .done(done1), .pass_count(pass1), .fail_count(fail1),
        .first_fail_valid(ffv1), .first_fail_index(ffi1),
        .first_fail_expected(ffe1), .first_fail_got(ffg1)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gold(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return a | b;
            2'b01:   return ~(a & b);
            2'b10:   return ~(a | b);
            default: return a & b;
        endcase
    endfunction

    // mode 0 ideal, 1 output stuck at 0, 2 NAND/NOR swapped
    function automatic logic [7:0] engine(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input int mode);
        if (mode == 1) return 8'h00;
        if (mode == 2 && op == 2'b01) return gold(a, b, 2'b10);
        if (mode == 2 && op == 2'b10) return gold(a, b, 2'b01);
        return gold(a, b, op);
    endfunction

    // {a, b, op} of vector idx, built from scratch each call
    function automatic logic [17:0] ref_vec(input int idx, input logic [7:0] sa, input logic [7:0] sb);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] tab_a [8] = '{8'hAA, 8'hF0, 8'hAA, 8'hF0, 8'h00, 8'hFF, 8'hA5, 8'hFF};
        logic [7:0] tab_b [8] = '{8'h55, 8'h0F, 8'h55, 8'hCC, 8'h00, 8'hFF, 8'hAA, 8'h00};
        logic [1:0] tab_o [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd1, 2'd2};
        if (idx < 8) return {tab_a[idx], tab_b[idx], tab_o[idx]};
        a = (sa == 8'h00) ? 8'h01 : sa;
        b = (sb == 8'h00) ? 8'h01 : sb;
        for (int k = 8; k < idx; k++) begin
            a = (a >> 1) ^ (a[0] ? 8'hB8 : 8'h00);
            b = (b >> 1) ^ (b[0] ? 8'hB8 : 8'h00);
        end
        return {a, b, 2'(idx)};
    endfunction

    task automatic ref_run(input int n, input logic [7:0] sa, input logic [7:0] sb, input int mode,
                           output int fails, output int first_idx,
                           output logic [7:0] first_exp, output logic [7:0] first_got);
        logic [17:0] v;
        logic [7:0]  g;
        logic [7:0]  r;
        fails = 0; first_idx = -1; first_exp = 8'h00; first_got = 8'h00;
        for (int i = 0; i < 8 + n; i++) begin
            v = ref_vec(i, sa, sb);
            g = gold(v[17:10], v[9:2], v[1:0]);
            r = engine(v[17:10], v[9:2], v[1:0], mode);
            if (g != r) begin
                if (fails == 0) begin first_idx = i; first_exp = g; first_got = r; end
                fails++;
            end
        end
    endtask

    always_comb bus0.eng_result = engine(bus0.eng_a, bus0.eng_b, bus0.eng_opcode, mode0);
    always_comb bus1.eng_result = engine(bus1.eng_a, bus1.eng_b, bus1.eng_opcode, mode1);

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] ops0();
        return {bus0.eng_a, bus0.eng_b, bus0.eng_opcode};
    endfunction

    function automatic logic [17:0] ops1();
        return {bus1.eng_a, bus1.eng_b, bus1.eng_opcode};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int         ticks;
        int         m_fails;
        int         m_idx;
        logic [7:0] m_exp;
        logic [7:0] m_got;

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode0 = 0; mode1 = 2;
        repeat (3) tick;
        chk("reset_flags",  64'({busy0, done0, ffv0, busy1, done1, ffv1}), 64'd0);
        chk("reset_counts", 64'({pass0, fail0}), 64'd0);
        chk("reset_ffcap",  64'({ffi0, ffe0, ffg0}), 64'd0);
        chk("reset_ops",    64'(ops0()), 64'd0);
        rst = 1'b0;
        tick;

        // Ideal engine, full default run with start/busy/operand timing.
        start0 = 1'b1;
        chk("busy_before_start", 64'(busy0), 64'd0);
        tick; ticks = 1; start0 = 1'b0;
        chk("busy_rise", 64'({busy0, done0}), 64'b10);
        tick; ticks++;
        chk("vec0_ops", 64'(ops0()), 64'(ref_vec(0, 8'hA5, 8'h5A)));
        repeat (3) begin tick; ticks++; end
        chk("vec1_ops", 64'(ops0()), 64'(ref_vec(1, 8'hA5, 8'h5A)));
        while (!done0 && ticks < 2000) begin tick; ticks++; end
        chk("run0_latency", 64'(ticks), 64'(1 + 264 * 3));
        chk("run0_flags",   64'({busy0, done0, ffv0}), 64'b010);
        chk("run0_pass",    64'(pass0), 64'd264);
        chk("run0_fail",    64'(fail0), 64'd0);
        chk("run0_ops_held", 64'(ops0()), 64'(ref_vec(263, 8'hA5, 8'h5A)));

        // Engine stuck at zero, restart from DONE, stray start mid-run.
        mode0 = 1;
        start0 = 1'b1;
        tick; ticks = 1; start0 = 1'b0;
        chk("restart_clears", 64'({busy0, done0, pass0, fail0}), 64'({1'b1, 1'b0, 16'd0, 16'd0}));
        repeat (10) begin tick; ticks++; end
        start0 = 1'b1;
        tick; ticks++; start0 = 1'b0;
        chk("start_while_busy", 64'(ops0()), 64'(ref_vec(3, 8'hA5, 8'h5A)));
        while (!done0 && ticks < 2000) begin tick; ticks++; end
        chk("run1_latency", 64'(ticks), 64'(1 + 264 * 3));
        ref_run(256, 8'hA5, 8'h5A, 1, m_fails, m_idx, m_exp, m_got);
        chk("zero_fail",  64'(fail0), 64'(m_fails));
        chk("zero_pass",  64'(pass0), 64'(264 - m_fails));
        chk("zero_ffcap", 64'({ffv0, ffi0, ffe0, ffg0}), 64'({1'b1, 16'(m_idx), m_exp, m_got}));
        chk("zero_ffcap_spec", 64'({ffi0, ffe0, ffg0}), 64'({16'd0, 8'hFF, 8'h00}));

        // Short run, zero seed replaced, settle 2, NAND/NOR swapped engine.
        start1 = 1'b1;
        tick; start1 = 1'b0;
        tick;
        for (int v = 0; v < 12; v++) begin
            chk($sformatf("dut1_vec%0d_ops", v), 64'(ops1()), 64'(ref_vec(v, 8'h00, 8'h3C)));
            repeat (4) tick;
        end
        chk("dut1_done", 64'({busy1, done1}), 64'b01);
        ref_run(4, 8'h00, 8'h3C, 2, m_fails, m_idx, m_exp, m_got);
        chk("swap_fail",  64'(fail1), 64'(m_fails));
        chk("swap_pass",  64'(pass1), 64'(12 - m_fails));
        chk("swap_ffcap", 64'({ffv1, ffi1, ffe1, ffg1}), 64'({1'b1, 16'(m_idx), m_exp, m_got}));
        chk("swap_ffcap_spec", 64'({ffi1, ffe1, ffg1}), 64'({16'd1, 8'hFF, 8'h00}));

        // Asynchronous reset mid-run, then a clean rerun.
        mode0 = 0;
        start0 = 1'b1;
        tick; start0 = 1'b0;
        repeat (16) tick;
        chk("pre_reset_vec5", 64'({pass0, ops0()}), 64'({16'd5, ref_vec(5, 8'hA5, 8'h5A)}));
        rst = 1'b1;
        #1;
        chk("async_reset_flags",  64'({busy0, done0, ffv0}), 64'd0);
        chk("async_reset_counts", 64'({pass0, fail0}), 64'd0);
        chk("async_reset_ops",    64'(ops0()), 64'd0);
        tick;
        rst = 1'b0;
        tick;
        start0 = 1'b1;
        tick; ticks = 1; start0 = 1'b0;
        repeat (3) begin tick; ticks++; end
        chk("rerun_pass_restart", 64'(pass0), 64'd1);
        while (ticks < 32) begin tick; ticks++; end
        chk("rerun_vec10_ops", 64'(ops0()), 64'(ref_vec(10, 8'hA5, 8'h5A)));
        while (!done0 && ticks < 2000) begin tick; ticks++; end
        chk("rerun_done", 64'({busy0, done0}), 64'b01);
        chk("rerun_counts", 64'({pass0, fail0}), 64'({16'd264, 16'd0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
